// File: rtl/up_bus_arbiter.sv
// Two-master round-robin arbiter for the up register bus, one transaction outstanding.
// Define UP_ARB_TIMEOUT_EN to force-complete WAIT after TIMEOUT_CYCLES without a matching ack.

module up_bus_arbiter_port (
  input  logic        up_clk,
  input  logic        up_rstn,
  input  logic        fin,
  input  logic        wr,
  input  logic [31:0] rd_val,
  output logic        wack,
  output logic        rack,
  output logic [31:0] rdata
);
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      wack  <= 1'b0;
      rack  <= 1'b0;
      rdata <= '0;
    end else begin
      wack <= fin & wr;
      rack <= fin & ~wr;
      if (fin & ~wr) rdata <= rd_val;
    end
  end
endmodule

module up_bus_arbiter #(
  parameter int ADDR_WIDTH     = 14,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  up_clk,
  input  logic                  up_rstn,
  input  logic                  m0_wreq,
  input  logic [ADDR_WIDTH-1:0] m0_waddr,
  input  logic [31:0]           m0_wdata,
  output logic                  m0_wack,
  input  logic                  m0_rreq,
  input  logic [ADDR_WIDTH-1:0] m0_raddr,
  output logic [31:0]           m0_rdata,
  output logic                  m0_rack,
  input  logic                  m1_wreq,
  input  logic [ADDR_WIDTH-1:0] m1_waddr,
  input  logic [31:0]           m1_wdata,
  output logic                  m1_wack,
  input  logic                  m1_rreq,
  input  logic [ADDR_WIDTH-1:0] m1_raddr,
  output logic [31:0]           m1_rdata,
  output logic                  m1_rack,
  output logic                  up_wreq,
  output logic [ADDR_WIDTH-1:0] up_waddr,
  output logic [31:0]           up_wdata,
  input  logic                  up_wack,
  output logic                  up_rreq,
  output logic [ADDR_WIDTH-1:0] up_raddr,
  input  logic [31:0]           up_rdata,
  input  logic                  up_rack,
  output logic [15:0]           up_timeout_cnt
);
  localparam int NM = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nxt;

  logic [NM-1:0]                 wreq_v, rreq_v, pend, fin_v, wack_v, rack_v;
  logic [NM-1:0][ADDR_WIDTH-1:0] waddr_v, raddr_v;
  logic [NM-1:0][31:0]           wdata_v, rdata_v;

  assign wreq_v  = {m1_wreq, m0_wreq};
  assign rreq_v  = {m1_rreq, m0_rreq};
  assign waddr_v = {m1_waddr, m0_waddr};
  assign raddr_v = {m1_raddr, m0_raddr};
  assign wdata_v = {m1_wdata, m0_wdata};
  assign pend    = wreq_v | rreq_v;

  logic sel, sel_wr, gnt, gnt_wr, last_grant, ack_match, expire, fin;

  // Tie goes to the master not served last; a write beats a read from the same master.
  assign sel       = (pend[0] & pend[1]) ? ~last_grant : pend[1];
  assign sel_wr    = wreq_v[sel];
  assign ack_match = gnt_wr ? up_wack : up_rack;
  assign fin       = (state == WAIT) & (ack_match | expire);

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|pend) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (fin) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      gnt        <= 1'b0;
      gnt_wr     <= 1'b0;
      last_grant <= 1'b1;
      up_wreq    <= 1'b0;
      up_rreq    <= 1'b0;
      up_waddr   <= '0;
      up_raddr   <= '0;
      up_wdata   <= '0;
    end else begin
      up_wreq <= 1'b0;
      up_rreq <= 1'b0;
      if (state == IDLE && |pend) begin
        gnt     <= sel;
        gnt_wr  <= sel_wr;
        up_wreq <= sel_wr;
        up_rreq <= ~sel_wr;
        if (sel_wr) begin
          up_waddr <= waddr_v[sel];
          up_wdata <= wdata_v[sel];
        end else begin
          up_raddr <= raddr_v[sel];
        end
      end
      if (state == DONE) last_grant <= gnt;
    end
  end

  for (genvar i = 0; i < NM; i++) begin : g_port
    assign fin_v[i] = fin & (gnt == 1'(i));
    up_bus_arbiter_port u_port (
      .up_clk  (up_clk),
      .up_rstn (up_rstn),
      .fin     (fin_v[i]),
      .wr      (gnt_wr),
      .rd_val  (ack_match ? up_rdata : 32'hDEAD_DEAD),
      .wack    (wack_v[i]),
      .rack    (rack_v[i]),
      .rdata   (rdata_v[i])
    );
  end

  assign m0_wack  = wack_v[0];
  assign m0_rack  = rack_v[0];
  assign m0_rdata = rdata_v[0];
  assign m1_wack  = wack_v[1];
  assign m1_rack  = rack_v[1];
  assign m1_rdata = rdata_v[1];

`ifdef UP_ARB_TIMEOUT_EN
  // Expiry fires on the TIMEOUT_CYCLES-th WAIT cycle; counter reads 0 on the first.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt;

  assign expire = (state == WAIT) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      tmo_cnt        <= '0;
      up_timeout_cnt <= '0;
    end else begin
      if (state == ISSUE)     tmo_cnt <= '0;
      else if (state == WAIT) tmo_cnt <= tmo_cnt + 16'd1;
      if (expire && !ack_match && up_timeout_cnt != 16'hFFFF)
        up_timeout_cnt <= up_timeout_cnt + 16'd1;
    end
  end
`else
  assign expire         = 1'b0;
  assign up_timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_up_bus_arbiter.sv
// Directed bench for up_bus_arbiter: hand-computed expectations, checks on the falling edge.

module tb_up_bus_arbiter;
  localparam int AW = 14;

  logic          up_clk, up_rstn;
  logic          m0_wreq, m0_rreq, m1_wreq, m1_rreq;
  logic [AW-1:0] m0_waddr, m0_raddr, m1_waddr, m1_raddr;
  logic [31:0]   m0_wdata, m1_wdata;
  logic          m0_wack, m0_rack, m1_wack, m1_rack;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          up_wreq, up_rreq, up_wack, up_rack;
  logic [AW-1:0] up_waddr, up_raddr;
  logic [31:0]   up_wdata, up_rdata;
  logic [15:0]   up_timeout_cnt;

  up_bus_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(255)) dut (
    .up_clk(up_clk), .up_rstn(up_rstn),
    .m0_wreq(m0_wreq), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata), .m0_wack(m0_wack),
    .m0_rreq(m0_rreq), .m0_raddr(m0_raddr), .m0_rdata(m0_rdata), .m0_rack(m0_rack),
    .m1_wreq(m1_wreq), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata), .m1_wack(m1_wack),
    .m1_rreq(m1_rreq), .m1_raddr(m1_raddr), .m1_rdata(m1_rdata), .m1_rack(m1_rack),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
    .up_timeout_cnt(up_timeout_cnt)
  );

  initial up_clk = 1'b0;
  always #5 up_clk = ~up_clk;

  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_rd [2];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge up_clk);
  endtask

  task automatic chk_acks0(input string tag);
    chk({tag, "_m0_wack"}, m0_wack, 0);
    chk({tag, "_m0_rack"}, m0_rack, 0);
    chk({tag, "_m1_wack"}, m1_wack, 0);
    chk({tag, "_m1_rack"}, m1_rack, 0);
  endtask

  task automatic chk_all0(input string tag);
    chk_acks0(tag);
    chk({tag, "_up_wreq"}, up_wreq, 0);
    chk({tag, "_up_rreq"}, up_rreq, 0);
    chk({tag, "_up_waddr"}, 32'(up_waddr), 0);
    chk({tag, "_up_raddr"}, 32'(up_raddr), 0);
    chk({tag, "_up_wdata"}, up_wdata, 0);
    chk({tag, "_m0_rdata"}, m0_rdata, 0);
    chk({tag, "_m1_rdata"}, m1_rdata, 0);
    chk({tag, "_tmo_cnt"}, 32'(up_timeout_cnt), 0);
  endtask

  task automatic do_reset;
    up_rstn = 1'b0;
    {m0_wreq, m0_rreq, m1_wreq, m1_rreq, up_wack, up_rack} = '0;
    {m0_waddr, m0_raddr, m1_waddr, m1_raddr} = '0;
    {m0_wdata, m1_wdata} = '0;
    up_rdata  = 32'h5A5A_5A5A;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    tick;
    chk_all0("reset");
    up_rstn = 1'b1;
    tick;
  endtask

  task automatic req_w(input bit m, input logic [AW-1:0] a, input logic [31:0] d);
    if (!m) begin m0_wreq = 1; m0_waddr = a; m0_wdata = d; end
    else    begin m1_wreq = 1; m1_waddr = a; m1_wdata = d; end
  endtask

  task automatic req_r(input bit m, input logic [AW-1:0] a);
    if (!m) begin m0_rreq = 1; m0_raddr = a; end
    else    begin m1_rreq = 1; m1_raddr = a; end
  endtask

  // Called on the falling edge of an IDLE cycle; the next rising edge samples requests.
  task automatic serve(input bit m, input bit wr, input logic [AW-1:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int dly);
    tick;
    chk("issue_wreq", up_wreq, wr);
    chk("issue_rreq", up_rreq, !wr);
    if (wr) begin
      chk("issue_waddr", 32'(up_waddr), 32'(a));
      chk("issue_wdata", up_wdata, wd);
    end else begin
      chk("issue_raddr", 32'(up_raddr), 32'(a));
    end
    tick;
    chk("one_pulse", {up_wreq, up_rreq}, 0);
    for (int i = 1; i < dly; i++) begin
      if (wr) up_rack = 1; else up_wack = 1;
      tick;
      up_rack = 0; up_wack = 0;
      chk_acks0("wait");
      chk("wait_addr", 32'(wr ? up_waddr : up_raddr), 32'(a));
    end
    if (wr) up_wack = 1; else up_rack = 1;
    up_rdata = rd;
    tick;
    up_wack = 0; up_rack = 0; up_rdata = 32'h5A5A_5A5A;
    if (!wr) exp_rd[m] = rd;
    chk("done_m0_wack", m0_wack, !m && wr);
    chk("done_m0_rack", m0_rack, !m && !wr);
    chk("done_m1_wack", m1_wack, m && wr);
    chk("done_m1_rack", m1_rack, m && !wr);
    chk("m0_rdata", m0_rdata, exp_rd[0]);
    chk("m1_rdata", m1_rdata, exp_rd[1]);
    case ({m, wr})
      2'b01: m0_wreq = 0;
      2'b00: m0_rreq = 0;
      2'b11: m1_wreq = 0;
      default: m1_rreq = 0;
    endcase
    tick;
    chk_acks0("idle");
    chk("no_reissue", {up_wreq, up_rreq}, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got time limit, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // single m0 write, slave acks in the first WAIT cycle
    do_reset;
    req_w(0, 14'h0040, 32'h1234_5678);
    serve(0, 1, 14'h0040, 32'h1234_5678, 0, 1);

    // simultaneous reads after reset: m0 wins the first tie
    do_reset;
    req_r(0, 14'h0100);
    req_r(1, 14'h0200);
    serve(0, 0, 14'h0100, 0, 32'hAAAA_0000, 1);
    serve(1, 0, 14'h0200, 0, 32'hBBBB_0000, 2);

    // continuous writes from both masters alternate m0, m1
    req_w(0, 14'h0010, 32'hD000_0000);
    req_w(1, 14'h0021, 32'hD000_0001);
    for (int i = 0; i < 6; i++) begin
      bit m;
      m = bit'(i % 2);
      serve(m, 1, 14'(16 * (i % 2 + 1) + i), 32'hD000_0000 | 32'(i), 0, 1 + i % 3);
      if (i + 2 < 6)
        req_w(m, 14'(16 * (i % 2 + 1) + i + 2), 32'hD000_0000 | 32'(i + 2));
    end

    // write and read together from m0: write first, read on the next grant
    req_w(0, 14'h0044, 32'hCAFE_F00D);
    req_r(0, 14'h0048);
    serve(0, 1, 14'h0044, 32'hCAFE_F00D, 0, 3);
    serve(0, 0, 14'h0048, 0, 32'h0123_4567, 1);

    // reset in WAIT abandons the access; a late slave ack is discarded
    req_w(0, 14'h0060, 32'h600D_BEEF);
    tick; tick; tick;
    up_rstn = 0;
    #1;
    chk_all0("rst_wait");
    m0_wreq = 0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    tick;
    up_rstn = 1;
    up_wack = 1;
    tick;
    up_wack = 0;
    chk_acks0("late_ack");
    chk("late_ack_noreq", {up_wreq, up_rreq}, 0);
    tick;
    chk_acks0("late_ack2");
    req_r(0, 14'h0064);
    serve(0, 0, 14'h0064, 0, 32'h7654_3210, 1);

`ifdef UP_ARB_TIMEOUT_EN
    // unmapped m1 read: forced completion after 255 WAIT cycles
    begin
      int n;
      req_r(1, 14'h3FFF);
      tick;
      chk("tmo_issue", up_rreq, 1);
      tick;
      n = 0;
      while (m1_rack !== 1'b1 && n < 400) begin
        tick;
        n++;
      end
      chk("tmo_latency", 32'(n), 255);
      chk("tmo_rdata", m1_rdata, 32'hDEAD_DEAD);
      chk("tmo_cnt", 32'(up_timeout_cnt), 1);
      chk("tmo_m0_rdata", m0_rdata, 32'h7654_3210);
      m1_rreq = 0;
      repeat (9) tick;
      up_rack = 1;
      up_rdata = 32'h1111_1111;
      tick;
      up_rack = 0;
      chk_acks0("tmo_late");
      chk("tmo_late_rdata", m1_rdata, 32'hDEAD_DEAD);
      chk("tmo_late_cnt", 32'(up_timeout_cnt), 1);
      tick;
      chk_acks0("tmo_late2");
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
